vision_test_ctrl: RTL and testbench
===================================

Name: vision_test_ctrl

Overview:
- Sequencing controller for the vision tester's optotype display.
- Runs the staircase test: picks a random gap direction per trial, holds the acuity level, scores debounced key answers, and steps the level up or down.
- Drives the 8×8 lattice renderer (direction, enable, level) and the BCD digits (DISP3~DISP2).
- Sits between the key debouncer and the lattice/seven-segment blocks.

Parameters:
START_LEVEL, 7, level index at test start (7 = acuity 0.8)
TIMEOUT_S, 5, whole 1 Hz ticks without confirm before a trial scores as wrong
FB_TICKS, 1, 1 Hz ticks the feedback state holds
LFSR_SEED, 8'h5A, LFSR value loaded at reset; must be non-zero

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
tick_1hz  input  1  one-clk-wide enable, once per second
start  input  1  debounced single-cycle pulse (BTN0)
key_up  input  1  debounced pulse, direction up
key_down  input  1  debounced pulse, direction down
key_left  input  1  debounced pulse, direction left
key_right  input  1  debounced pulse, direction right
confirm  input  1  debounced pulse, commit answer (BTN1)
opto_en  output  1  lattice shows optotype
opto_dir  output  2  gap direction: 00 up, 01 down, 10 left, 11 right
level  output  4  current level index, 0..11
acuity_bcd  output  8  two BCD digits, acuity ×10
fb_correct  output  1  high during feedback after a correct answer
fb_wrong  output  1  high during feedback after a wrong answer or timeout
busy  output  1  test in progress
done  output  1  test finished; acuity_bcd holds the result

Behaviour:

Reset (async, rst=0):
- State IDLE; all outputs 0.
- LFSR loads LFSR_SEED.
- Internal flags, counters and the answer latch clear.

Level table (index → acuity_bcd):
- 0..8 → 01 to 09.
- 9 → 10; 10 → 12; 11 → 15.
- acuity_bcd follows `level` combinationally in PRESENT/WAIT_ANS/FEEDBACK.
- acuity_bcd is 00 in IDLE; in DONE it shows the result.

LFSR:
- 8-bit Fibonacci, taps 8,6,5,4.
- Shifts left every clk in every state except reset; feedback enters bit 0.

States:
- IDLE: wait for start.
  - start → PRESENT.
  - level=START_LEVEL; correct-count=0; came_up=0; came_down=0.
- PRESENT (1 clk):
  - cand=lfsr[1:0]. If cand equals the previous trial's direction, use cand+1 mod 4. The first trial after start has no previous direction.
  - Register the result into opto_dir; clear the answer latch and the timeout counter → WAIT_ANS.
  - opto_en=1 from this cycle onward.
- WAIT_ANS:
  - A direction pulse overwrites the answer latch.
  - Several direction pulses in the same cycle: priority up>down>left>right.
  - confirm with the latch empty: ignored.
  - confirm with a valid latch: score → FEEDBACK. A direction pulse in the same cycle as confirm is latched first and then committed.
  - Each tick_1hz increments the timeout counter. When it reaches TIMEOUT_S, score wrong → FEEDBACK.
  - confirm and the final tick in the same cycle: confirm wins.
- FEEDBACK:
  - opto_en=0; fb_correct or fb_wrong held high.
  - Hold for FB_TICKS tick_1hz pulses, then apply the step rule:
  - Correct: correct-count++.
    - If the count reaches 2 and came_down=1 → DONE, result=level.
    - If the count reaches 2 and level=11 → DONE, result=11.
    - Otherwise, at 2: level++, came_up=1, count=0.
    - Count below 2 → PRESENT.
  - Wrong:
    - came_up=1 → DONE, result=level-1.
    - level=0 → DONE, result code 00.
    - Otherwise: level--, came_down=1, count=0 → PRESENT.
  - After a non-DONE step rule → PRESENT.
- DONE:
  - done=1, busy=0, opto_en=0.
  - acuity_bcd = table[result], or 00 for fail.
  - start → PRESENT with the IDLE-start initialisation.

Other rules:
- busy=1 in PRESENT, WAIT_ANS and FEEDBACK.
- start pulse in PRESENT/WAIT_ANS/FEEDBACK restarts the test: same initialisation as IDLE, next state PRESENT.
- Outputs are registered except acuity_bcd. No output glitches on the state transition edge.

Test Plan:
- Reset then start → next clk busy=1, level=7, acuity_bcd=0x08. Following clk: opto_en=1, opto_dir = bench LFSR model value.
- Answer opto_dir + confirm twice → fb_correct for FB_TICKS ticks, then level=8 (0x09). Then one wrong → done=1, acuity_bcd=0x08.
- From start: wrong → level=6 (0x07). Then two corrects → done=1, acuity_bcd=0x07.
- Confirm with no prior direction key → no state change. key_left and key_up in the same cycle with confirm → answer=up.
- No keys for 5 ticks → fb_wrong. Confirm coincident with the 5th tick → scored from the latch, not as a timeout.
- Eight consecutive wrongs from level 7 → done, acuity_bcd=0x00.
- Pass to level 11 → done, 0x15.
- Start mid-WAIT_ANS restarts at level 7.
- Async rst low mid-FEEDBACK → all outputs 0 immediately.

Source files
------------

// File: rtl/vision_test_ctrl.sv
// Staircase acuity-test sequencer for the vision tester's optotype display.
// Picks a random gap direction per trial, scores debounced key answers,
// steps the acuity level and reports the result as two BCD digits.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for start, display blank
// S_PRESENT  | one clock: choose and register the next gap direction
// S_WAIT_ANS | optotype shown, collecting direction keys / confirm / timeout
// S_FEEDBACK | optotype hidden, correct/wrong indication held for FB_TICKS
// S_DONE     | test finished, acuity_bcd shows the result
module vision_test_ctrl #(
  parameter int unsigned START_LEVEL = 7,
  parameter int unsigned TIMEOUT_S   = 5,
  parameter int unsigned FB_TICKS    = 1,
  parameter logic [7:0]  LFSR_SEED   = 8'h5A
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       confirm,
  output logic       opto_en,
  output logic [1:0] opto_dir,
  output logic [3:0] level,
  output logic [7:0] acuity_bcd,
  output logic       fb_correct,
  output logic       fb_wrong,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PRESENT  = 3'd1,
    S_WAIT_ANS = 3'd2,
    S_FEEDBACK = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [3:0] START_LVL = 4'(START_LEVEL);
  localparam logic [3:0] TOP_LVL   = 4'd11;
  localparam logic [7:0] TO_LOAD   = 8'(TIMEOUT_S);
  localparam logic [7:0] FB_LOAD   = 8'(FB_TICKS);

  state_t      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        lfsr_fb;
  logic [3:0]  level_q, level_d;
  logic [1:0]  corr_cnt_q, corr_cnt_d;
  logic        came_up_q, came_up_d;
  logic        came_down_q, came_down_d;
  logic        prev_valid_q, prev_valid_d;
  logic        ans_valid_q, ans_valid_d;
  logic [1:0]  ans_dir_q, ans_dir_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [7:0]  fb_cnt_q, fb_cnt_d;
  logic [3:0]  result_q, result_d;
  logic        result_fail_q, result_fail_d;

  logic        opto_en_q, opto_en_d;
  logic [1:0]  opto_dir_q, opto_dir_d;
  logic        fb_correct_q, fb_correct_d;
  logic        fb_wrong_q, fb_wrong_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        key_any;
  logic [1:0]  key_dir;
  logic        ans_eff_valid;
  logic [1:0]  ans_eff_dir;
  logic [1:0]  cand;
  logic        enter_fb;
  logic        score_ok;

  // Taps 8,6,5,4 (bits 7,5,4,3); shifted left, feedback into bit 0.
  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

  // Key decode with fixed priority up > down > left > right.
  always_comb begin
    key_any = key_up | key_down | key_left | key_right;
    key_dir = 2'd3;
    if (key_up)        key_dir = 2'd0;
    else if (key_down) key_dir = 2'd1;
    else if (key_left) key_dir = 2'd2;
    // A key pressed together with confirm is latched first, then committed.
    ans_eff_valid = key_any | ans_valid_q;
    ans_eff_dir   = key_any ? key_dir : ans_dir_q;
  end

  // Next-state, datapath and registered-output next values.
  always_comb begin
    state_d       = state_q;
    lfsr_d        = {lfsr_q[6:0], lfsr_fb};
    level_d       = level_q;
    corr_cnt_d    = corr_cnt_q;
    came_up_d     = came_up_q;
    came_down_d   = came_down_q;
    prev_valid_d  = prev_valid_q;
    ans_valid_d   = ans_valid_q;
    ans_dir_d     = ans_dir_q;
    to_cnt_d      = to_cnt_q;
    fb_cnt_d      = fb_cnt_q;
    result_d      = result_q;
    result_fail_d = result_fail_q;
    opto_dir_d    = opto_dir_q;
    enter_fb      = 1'b0;
    score_ok      = 1'b0;
    cand          = lfsr_q[1:0];

    if (start) begin
      // Start restarts from any state.
      level_d      = START_LVL;
      corr_cnt_d   = 2'd0;
      came_up_d    = 1'b0;
      came_down_d  = 1'b0;
      prev_valid_d = 1'b0;
      state_d      = S_PRESENT;
    end else begin
      unique case (state_q)
        S_IDLE: begin
        end
        S_PRESENT: begin
          // Never show the same gap direction twice in a row.
          if (prev_valid_q && (cand == opto_dir_q)) cand = cand + 2'd1;
          opto_dir_d   = cand;
          prev_valid_d = 1'b1;
          ans_valid_d  = 1'b0;
          to_cnt_d     = TO_LOAD;
          state_d      = S_WAIT_ANS;
        end
        S_WAIT_ANS: begin
          if (key_any) begin
            ans_valid_d = 1'b1;
            ans_dir_d   = key_dir;
          end
          if (confirm && ans_eff_valid) begin
            score_ok = (ans_eff_dir == opto_dir_q);
            enter_fb = 1'b1;
          end else if (tick_1hz) begin
            if (to_cnt_q > 8'd1) begin
              to_cnt_d = to_cnt_q - 8'd1;
            end else begin
              score_ok = 1'b0;
              enter_fb = 1'b1;
            end
          end
          if (enter_fb) begin
            fb_cnt_d = FB_LOAD;
            state_d  = S_FEEDBACK;
          end
        end
        S_FEEDBACK: begin
          if (tick_1hz) begin
            if (fb_cnt_q > 8'd1) begin
              fb_cnt_d = fb_cnt_q - 8'd1;
            end else if (fb_correct_q) begin
              if (corr_cnt_q == 2'd1) begin
                if (came_down_q) begin
                  result_d      = level_q;
                  result_fail_d = 1'b0;
                  state_d       = S_DONE;
                end else if (level_q == TOP_LVL) begin
                  result_d      = TOP_LVL;
                  result_fail_d = 1'b0;
                  state_d       = S_DONE;
                end else begin
                  level_d    = level_q + 4'd1;
                  came_up_d  = 1'b1;
                  corr_cnt_d = 2'd0;
                  state_d    = S_PRESENT;
                end
              end else begin
                corr_cnt_d = corr_cnt_q + 2'd1;
                state_d    = S_PRESENT;
              end
            end else begin
              if (came_up_q) begin
                // came_up implies level was stepped up, so level_q >= 1.
                result_d      = level_q - 4'd1;
                result_fail_d = 1'b0;
                state_d       = S_DONE;
              end else if (level_q == 4'd0) begin
                result_d      = 4'd0;
                result_fail_d = 1'b1;
                state_d       = S_DONE;
              end else begin
                level_d     = level_q - 4'd1;
                came_down_d = 1'b1;
                corr_cnt_d  = 2'd0;
                state_d     = S_PRESENT;
              end
            end
          end
        end
        S_DONE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Outputs are decoded from the next state so they change with the state.
    opto_en_d    = (state_d == S_WAIT_ANS);
    busy_d       = (state_d == S_PRESENT) || (state_d == S_WAIT_ANS) ||
                   (state_d == S_FEEDBACK);
    done_d       = (state_d == S_DONE);
    fb_correct_d = (state_d == S_FEEDBACK) && (enter_fb ? score_ok : fb_correct_q);
    fb_wrong_d   = (state_d == S_FEEDBACK) && (enter_fb ? !score_ok : fb_wrong_q);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Datapath registers: LFSR, level tracking, answer latch and timers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q        <= LFSR_SEED;
      level_q       <= 4'd0;
      corr_cnt_q    <= 2'd0;
      came_up_q     <= 1'b0;
      came_down_q   <= 1'b0;
      prev_valid_q  <= 1'b0;
      ans_valid_q   <= 1'b0;
      ans_dir_q     <= 2'd0;
      to_cnt_q      <= 8'd0;
      fb_cnt_q      <= 8'd0;
      result_q      <= 4'd0;
      result_fail_q <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      level_q       <= level_d;
      corr_cnt_q    <= corr_cnt_d;
      came_up_q     <= came_up_d;
      came_down_q   <= came_down_d;
      prev_valid_q  <= prev_valid_d;
      ans_valid_q   <= ans_valid_d;
      ans_dir_q     <= ans_dir_d;
      to_cnt_q      <= to_cnt_d;
      fb_cnt_q      <= fb_cnt_d;
      result_q      <= result_d;
      result_fail_q <= result_fail_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opto_en_q    <= 1'b0;
      opto_dir_q   <= 2'd0;
      fb_correct_q <= 1'b0;
      fb_wrong_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      opto_en_q    <= opto_en_d;
      opto_dir_q   <= opto_dir_d;
      fb_correct_q <= fb_correct_d;
      fb_wrong_q   <= fb_wrong_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  // Level index to acuity x10 as two BCD digits.
  function automatic logic [7:0] lvl_to_bcd(input logic [3:0] lvl);
    logic [7:0] b;
    b = 8'h00;
    if (lvl <= 4'd8)       b = {4'h0, lvl + 4'd1};
    else if (lvl == 4'd9)  b = 8'h10;
    else if (lvl == 4'd10) b = 8'h12;
    else if (lvl == 4'd11) b = 8'h15;
    return b;
  endfunction

  // Acuity display follows the registered state, so it cannot glitch mid-edge.
  always_comb begin
    acuity_bcd = 8'h00;
    unique case (state_q)
      S_PRESENT, S_WAIT_ANS, S_FEEDBACK: acuity_bcd = lvl_to_bcd(level_q);
      S_DONE:  acuity_bcd = result_fail_q ? 8'h00 : lvl_to_bcd(result_q);
      default: acuity_bcd = 8'h00;
    endcase
  end

  assign opto_en    = opto_en_q;
  assign opto_dir   = opto_dir_q;
  assign level      = level_q;
  assign fb_correct = fb_correct_q;
  assign fb_wrong   = fb_wrong_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_vision_test_ctrl.sv
// Directed bench for vision_test_ctrl with an expected-value queue and a
// reference LFSR for the displayed gap direction.
module tb_vision_test_ctrl;

  localparam logic [7:0] SEED = 8'h5A;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0, start = 1'b0, confirm = 1'b0;
  logic       key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       opto_en, fb_correct, fb_wrong, busy, done;
  logic [1:0] opto_dir;
  logic [3:0] level;
  logic [7:0] acuity_bcd;

  vision_test_ctrl #(
    .START_LEVEL(7), .TIMEOUT_S(5), .FB_TICKS(1), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .start(start),
    .key_up(key_up), .key_down(key_down), .key_left(key_left),
    .key_right(key_right), .confirm(confirm),
    .opto_en(opto_en), .opto_dir(opto_dir), .level(level),
    .acuity_bcd(acuity_bcd), .fb_correct(fb_correct), .fb_wrong(fb_wrong),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference LFSR: taps 8,6,5,4, shift left, feedback into bit 0.
  logic [7:0] m;
  always @(posedge clk or negedge rst) begin
    if (!rst) m <= SEED;
    else      m <= {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  end

  typedef struct {
    int         sel;
    logic [7:0] exp;
  } exp_t;
  exp_t sb[$];

  int    vectors = 0;
  int    miscompares = 0;
  string phase = "init";

  logic       prev_ok = 1'b0;
  logic [1:0] prev_d = 2'd0;
  logic [1:0] cur_dir = 2'd0;

  // Input vector bits: start, up, down, left, right, confirm, tick.
  localparam logic [6:0] V_START = 7'b1000000;
  localparam logic [6:0] V_CONF  = 7'b0000010;
  localparam logic [6:0] V_TICK  = 7'b0000001;
  localparam logic [6:0] V_UP    = 7'b0100000;
  localparam logic [6:0] V_LEFT  = 7'b0001000;

  function automatic logic [6:0] key_of(input logic [1:0] d);
    logic [6:0] k;
    k = 7'b0100000 >> d;
    return k;
  endfunction

  function automatic string sig_name(input int sel);
    case (sel)
      0: return "opto_en";
      1: return "opto_dir";
      2: return "level";
      3: return "acuity_bcd";
      4: return "fb_correct";
      5: return "fb_wrong";
      6: return "busy";
      default: return "done";
    endcase
  endfunction

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      0: return {7'd0, opto_en};
      1: return {6'd0, opto_dir};
      2: return {4'd0, level};
      3: return acuity_bcd;
      4: return {7'd0, fb_correct};
      5: return {7'd0, fb_wrong};
      6: return {7'd0, busy};
      default: return {7'd0, done};
    endcase
  endfunction

  task automatic push(input int sel, input logic [7:0] e);
    exp_t x;
    x.sel = sel;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check();
    exp_t       e;
    logic [7:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sel);
      vectors++;
      assert (o === e.exp) else begin
        miscompares++;
        $error("FAIL %s/%s observed=%0h expected=%0h", phase, sig_name(e.sel), o, e.exp);
      end
    end
  endtask

  // One clock with the given inputs, sampled at the posedge, then cleared.
  task automatic apply(input logic [6:0] v);
    {start, key_up, key_down, key_left, key_right, confirm, tick_1hz} = v;
    @(negedge clk);
    {start, key_up, key_down, key_left, key_right, confirm, tick_1hz} = 7'd0;
  endtask

  task automatic push_all_zero();
    for (int s = 0; s < 8; s++) push(s, 8'h00);
  endtask

  task automatic do_start();
    apply(V_START);
    prev_ok = 1'b0;
    push(6, 8'd1); push(2, 8'd7); push(3, 8'h08); push(7, 8'd0);
    push(4, 8'd0); push(5, 8'd0);
    check();
  endtask

  // Called while the DUT sits in PRESENT: m equals the DUT LFSR here.
  task automatic present_step();
    logic [1:0] c;
    c = m[1:0];
    if (prev_ok && (c == prev_d)) c = c + 2'd1;
    prev_d  = c;
    prev_ok = 1'b1;
    cur_dir = c;
    apply(7'd0);
    push(0, 8'd1); push(1, {6'd0, c}); push(6, 8'd1);
    check();
  endtask

  task automatic score(input bit correct);
    logic [1:0] d;
    d = correct ? cur_dir : cur_dir + 2'd1;
    apply(key_of(d));
    apply(V_CONF);
    push(4, {7'd0, correct}); push(5, {7'd0, !correct}); push(0, 8'd0); push(6, 8'd1);
    check();
  endtask

  initial begin
    phase = "reset";
    repeat (3) @(negedge clk);
    push_all_zero();
    check();
    rst = 1'b1;
    apply(7'd0);
    apply(7'd0);

    phase = "up_then_wrong";
    do_start();
    present_step();
    score(1'b1);
    apply(V_TICK);
    push(2, 8'd7); push(4, 8'd0); push(6, 8'd1);
    check();
    present_step();
    score(1'b1);
    apply(V_TICK);
    push(2, 8'd8); push(3, 8'h09);
    check();
    present_step();
    score(1'b0);
    apply(V_TICK);
    push(7, 8'd1); push(6, 8'd0); push(3, 8'h08); push(0, 8'd0); push(5, 8'd0);
    check();

    phase = "down_then_pass";
    do_start();
    present_step();
    score(1'b0);
    apply(V_TICK);
    push(2, 8'd6); push(3, 8'h07);
    check();
    present_step();
    score(1'b1);
    apply(V_TICK);
    present_step();
    score(1'b1);
    apply(V_TICK);
    push(7, 8'd1); push(3, 8'h07);
    check();

    phase = "empty_confirm";
    do_start();
    present_step();
    apply(V_CONF);
    push(0, 8'd1); push(4, 8'd0); push(5, 8'd0); push(6, 8'd1);
    check();
    phase = "key_priority";
    apply(V_CONF | V_UP | V_LEFT);
    push(4, {7'd0, cur_dir == 2'd0}); push(5, {7'd0, cur_dir != 2'd0});
    check();
    apply(V_TICK);
    phase = "latch_overwrite";
    do_start();
    present_step();
    apply(key_of(cur_dir + 2'd2));
    apply(key_of(cur_dir));
    apply(V_CONF);
    push(4, 8'd1); push(5, 8'd0);
    check();
    apply(V_TICK);

    phase = "timeout";
    do_start();
    present_step();
    for (int i = 0; i < 4; i++) begin
      apply(V_TICK);
      apply(7'd0);
    end
    push(0, 8'd1); push(5, 8'd0); push(4, 8'd0);
    check();
    apply(V_TICK);
    push(5, 8'd1); push(4, 8'd0); push(0, 8'd0);
    check();
    apply(V_TICK);
    push(2, 8'd6);
    check();
    phase = "confirm_on_last_tick";
    present_step();
    for (int i = 0; i < 4; i++) apply(V_TICK);
    apply(key_of(cur_dir));
    apply(V_CONF | V_TICK);
    push(4, 8'd1); push(5, 8'd0);
    check();
    apply(V_TICK);
    push(2, 8'd6); push(6, 8'd1);
    check();
    present_step();

    phase = "restart_mid_wait";
    apply(key_of(cur_dir));
    do_start();
    present_step();

    phase = "eight_wrongs";
    for (int i = 0; i < 8; i++) begin
      score(1'b0);
      apply(V_TICK);
      if (i < 7) begin
        push(2, 8'(6 - i));
        check();
        present_step();
      end else begin
        push(7, 8'd1); push(3, 8'h00); push(2, 8'd0); push(6, 8'd0);
        check();
      end
    end

    phase = "climb_to_top";
    do_start();
    present_step();
    for (int lv = 7; lv <= 11; lv++) begin
      score(1'b1);
      apply(V_TICK);
      present_step();
      score(1'b1);
      apply(V_TICK);
      if (lv < 11) begin
        push(2, 8'(lv + 1));
        check();
        present_step();
      end else begin
        push(7, 8'd1); push(3, 8'h15); push(6, 8'd0);
        check();
      end
    end

    phase = "reset_in_feedback";
    do_start();
    present_step();
    score(1'b1);
    #2 rst = 1'b0;
    #1;
    push_all_zero();
    check();
    @(negedge clk);
    rst = 1'b1;
    apply(7'd0);
    push_all_zero();
    check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
